// File: rtl/fdt_dispatch.sv
// First-detection-table dispatcher: per-size-class row full bitmaps, lowest-free-row lookup,
// single-cycle search/fail issue and a post-issue request lock window.
module fdt_dispatch #(
  parameter int FDT_INDEX_WIDTH = 6,
  parameter int REQ_ID_WIDTH    = 8,
  parameter int LOCK_CYCLES     = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [REQ_ID_WIDTH-1:0]    req_id,
  input  logic [1:0]                 req_size,
  output logic                       alloc_valid_fdt_out,
  output logic [REQ_ID_WIDTH-1:0]    alloc_id_fdt_out,
  output logic [FDT_INDEX_WIDTH-1:0] alloc_pos_fdt_out,
  output logic [1:0]                 alloc_size_fdt_out,
  output logic                       fail_valid,
  output logic [REQ_ID_WIDTH-1:0]    fail_id,
  input  logic                       fdt_update_valid,
  input  logic [FDT_INDEX_WIDTH-1:0] fdt_update_idx,
  input  logic [3:0]                 fdt_update_bit_sequence,
  output logic [3:0]                 class_full
);

  localparam int ROWS  = 1 << FDT_INDEX_WIDTH;
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                     state, state_next;
  logic [CNT_W-1:0]           lock_cnt, lock_cnt_next;
  logic [3:0][ROWS-1:0]       full, full_next;
  logic [ROWS-1:0]            lookup_row;
  logic                       found;
  logic [FDT_INDEX_WIDTH-1:0] hit_pos;
  logic                       accept;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid & req_ready;

  // Updated bitmap doubles as the bypassed lookup source and the next register value.
  always_comb begin
    full_next = full;
    if (fdt_update_valid) begin
      for (int s = 0; s < 4; s++) begin
        full_next[s][fdt_update_idx] = fdt_update_bit_sequence[s];
      end
    end
  end

  assign lookup_row = full_next[req_size];

  always_comb begin
    found   = 1'b0;
    hit_pos = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!lookup_row[i]) begin
        found   = 1'b1;
        hit_pos = FDT_INDEX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    case (state)
      IDLE: begin
        if (accept && found) begin
          state_next    = LOCK;
          lock_cnt_next = CNT_W'(LOCK_CYCLES);
        end
      end
      LOCK: begin
        lock_cnt_next = lock_cnt - CNT_W'(1);
        if (lock_cnt == CNT_W'(1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next    = IDLE;
        lock_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_cnt <= '0;
      full     <= '0;
    end else begin
      state    <= state_next;
      lock_cnt <= lock_cnt_next;
      full     <= full_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_valid_fdt_out <= 1'b0;
      alloc_id_fdt_out    <= '0;
      alloc_pos_fdt_out   <= '0;
      alloc_size_fdt_out  <= '0;
      fail_valid          <= 1'b0;
      fail_id             <= '0;
      class_full          <= '0;
    end else begin
      alloc_valid_fdt_out <= accept & found;
      fail_valid          <= accept & ~found;
      if (accept && found) begin
        alloc_id_fdt_out   <= req_id;
        alloc_pos_fdt_out  <= hit_pos;
        alloc_size_fdt_out <= req_size;
      end
      if (accept && !found) begin
        fail_id <= req_id;
      end
      for (int s = 0; s < 4; s++) begin
        class_full[s] <= &full_next[s];
      end
    end
  end

endmodule

// File: tb/tb_fdt_dispatch.sv
// Directed bench for fdt_dispatch: vector table for allocation/lock/update behaviour,
// plus hand sequences for table fill, fail handling, reset mid-lock and bypass.
module tb_fdt_dispatch;

  localparam int IW = 6;
  localparam int DW = 8;
  localparam int LC = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_id;
  logic [1:0]    req_size;
  logic          alloc_valid_fdt_out;
  logic [DW-1:0] alloc_id_fdt_out;
  logic [IW-1:0] alloc_pos_fdt_out;
  logic [1:0]    alloc_size_fdt_out;
  logic          fail_valid;
  logic [DW-1:0] fail_id;
  logic          fdt_update_valid;
  logic [IW-1:0] fdt_update_idx;
  logic [3:0]    fdt_update_bit_sequence;
  logic [3:0]    class_full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rv;
    logic [DW-1:0] id;
    logic [1:0]    sz;
    logic          uv;
    logic [IW-1:0] ui;
    logic [3:0]    us;
    logic          e_ready;
    logic          e_alloc;
    logic [IW-1:0] e_pos;
    logic [1:0]    e_size;
    logic [DW-1:0] e_id;
    logic          e_fail;
    logic [DW-1:0] e_fid;
    logic [3:0]    e_cf;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fdt_dispatch #(
    .FDT_INDEX_WIDTH(IW),
    .REQ_ID_WIDTH   (DW),
    .LOCK_CYCLES    (LC)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_id                  (req_id),
    .req_size                (req_size),
    .alloc_valid_fdt_out     (alloc_valid_fdt_out),
    .alloc_id_fdt_out        (alloc_id_fdt_out),
    .alloc_pos_fdt_out       (alloc_pos_fdt_out),
    .alloc_size_fdt_out      (alloc_size_fdt_out),
    .fail_valid              (fail_valid),
    .fail_id                 (fail_id),
    .fdt_update_valid        (fdt_update_valid),
    .fdt_update_idx          (fdt_update_idx),
    .fdt_update_bit_sequence (fdt_update_bit_sequence),
    .class_full              (class_full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, sample #1 after the edge, then return inputs to idle.
  task automatic applyStimulus(input logic rv, input logic [DW-1:0] id, input logic [1:0] sz,
                               input logic uv, input logic [IW-1:0] ui, input logic [3:0] us);
    req_valid               = rv;
    req_id                  = id;
    req_size                = sz;
    fdt_update_valid        = uv;
    fdt_update_idx          = ui;
    fdt_update_bit_sequence = us;
    @(posedge clk);
    #1;
    req_valid        = 1'b0;
    fdt_update_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic e_ready, input logic e_alloc,
                             input logic [IW-1:0] e_pos, input logic [1:0] e_size,
                             input logic [DW-1:0] e_id, input logic e_fail,
                             input logic [DW-1:0] e_fid, input logic [3:0] e_cf);
    chk({tag, " req_ready"}, req_ready, e_ready);
    chk({tag, " alloc_valid"}, alloc_valid_fdt_out, e_alloc);
    chk({tag, " fail_valid"}, fail_valid, e_fail);
    chk({tag, " class_full"}, class_full, e_cf);
    if (e_alloc) begin
      chk({tag, " alloc_pos"}, alloc_pos_fdt_out, e_pos);
      chk({tag, " alloc_size"}, alloc_size_fdt_out, e_size);
      chk({tag, " alloc_id"}, alloc_id_fdt_out, e_id);
    end
    if (e_fail) chk({tag, " fail_id"}, fail_id, e_fid);
  endtask

  task automatic idleCheck(input string tag, input logic e_ready, input logic [3:0] e_cf);
    applyStimulus(1'b0, '0, 2'd0, 1'b0, '0, 4'd0);
    checkOutput(tag, e_ready, 1'b0, '0, 2'd0, '0, 1'b0, '0, e_cf);
  endtask

  task automatic lockTail(input string tag, input logic [3:0] e_cf);
    for (int i = 0; i < LC - 1; i++) idleCheck({tag, " lock"}, 1'b0, e_cf);
    idleCheck({tag, " unlock"}, 1'b1, e_cf);
  endtask

  task automatic addVec(input logic rv, input logic [DW-1:0] id, input logic [1:0] sz,
                        input logic uv, input logic [IW-1:0] ui, input logic [3:0] us,
                        input logic e_ready, input logic e_alloc, input logic [IW-1:0] e_pos,
                        input logic [1:0] e_size, input logic [DW-1:0] e_id,
                        input logic e_fail, input logic [DW-1:0] e_fid, input logic [3:0] e_cf);
    vec_t v;
    v.rv = rv; v.id = id; v.sz = sz; v.uv = uv; v.ui = ui; v.us = us;
    v.e_ready = e_ready; v.e_alloc = e_alloc; v.e_pos = e_pos; v.e_size = e_size;
    v.e_id = e_id; v.e_fail = e_fail; v.e_fid = e_fid; v.e_cf = e_cf;
    vecs.push_back(v);
  endtask

  task automatic addLockTail();
    for (int i = 0; i < LC - 1; i++) addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    addVec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0);
  endtask

  initial begin
    req_valid               = 1'b0;
    req_id                  = '0;
    req_size                = 2'd0;
    fdt_update_valid        = 1'b0;
    fdt_update_idx          = '0;
    fdt_update_bit_sequence = 4'd0;
    rst_n                   = 1'b0;

    // Table: first allocation and lock window, blocked request, class-0 fill then lookup, bypass on class 1.
    addVec(1, 8'd5, 2'd1, 0, 0, 0, 0, 1, 6'd0, 2'd1, 8'd5, 0, 0, 4'd0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    addVec(1, 8'h66, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    addVec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0);
    addVec(0, 0, 0, 1, 6'd0, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 4'd0);
    addVec(0, 0, 0, 1, 6'd1, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 4'd0);
    addVec(0, 0, 0, 1, 6'd2, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 4'd0);
    addVec(1, 8'd7, 2'd0, 0, 0, 0, 0, 1, 6'd3, 2'd0, 8'd7, 0, 0, 4'd0);
    addLockTail();
    addVec(1, 8'd9, 2'd1, 1, 6'd0, 4'b0010, 0, 1, 6'd1, 2'd1, 8'd9, 0, 0, 4'd0);
    addLockTail();

    #2;
    checkOutput("reset", 1'b1, 1'b0, '0, 2'd0, '0, 1'b0, '0, 4'd0);
    chk("reset alloc_id", alloc_id_fdt_out, 0);
    chk("reset alloc_pos", alloc_pos_fdt_out, 0);
    chk("reset fail_id", fail_id, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rv, vecs[i].id, vecs[i].sz, vecs[i].uv, vecs[i].ui, vecs[i].us);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_alloc, vecs[i].e_pos,
                  vecs[i].e_size, vecs[i].e_id, vecs[i].e_fail, vecs[i].e_fid, vecs[i].e_cf);
    end

    // Fill every row as class-3 full, then fails back-to-back, then free one row.
    for (int r = 0; r < (1 << IW); r++) begin
      applyStimulus(1'b0, '0, 2'd0, 1'b1, IW'(r), 4'b1000);
      chk($sformatf("fill%0d class_full", r), class_full, (r == (1 << IW) - 1) ? 4'b1000 : 4'b0000);
    end
    applyStimulus(1'b1, 8'h33, 2'd3, 1'b0, '0, 4'd0);
    checkOutput("fail1", 1'b1, 1'b0, '0, 2'd0, '0, 1'b1, 8'h33, 4'b1000);
    applyStimulus(1'b1, 8'h34, 2'd3, 1'b0, '0, 4'd0);
    checkOutput("fail2", 1'b1, 1'b0, '0, 2'd0, '0, 1'b1, 8'h34, 4'b1000);
    idleCheck("after fail", 1'b1, 4'b1000);
    applyStimulus(1'b0, '0, 2'd0, 1'b1, 6'd10, 4'b0000);
    checkOutput("free row10", 1'b1, 1'b0, '0, 2'd0, '0, 1'b0, '0, 4'b0000);
    applyStimulus(1'b1, 8'h36, 2'd3, 1'b0, '0, 4'd0);
    checkOutput("alloc row10", 1'b0, 1'b1, 6'd10, 2'd3, 8'h36, 1'b0, '0, 4'b0000);
    lockTail("row10", 4'b0000);

    // Reset during the issue/lock window: no pulse afterwards and bitmaps cleared.
    applyStimulus(1'b0, '0, 2'd0, 1'b1, 6'd0, 4'b0100);
    applyStimulus(1'b1, 8'h40, 2'd2, 1'b0, '0, 4'd0);
    checkOutput("pre-reset alloc", 1'b0, 1'b1, 6'd1, 2'd2, 8'h40, 1'b0, '0, 4'b0000);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-lock reset", 1'b1, 1'b0, '0, 2'd0, '0, 1'b0, '0, 4'd0);
    chk("mid-lock reset alloc_pos", alloc_pos_fdt_out, 0);
    chk("mid-lock reset alloc_id", alloc_id_fdt_out, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idleCheck("post-reset idle1", 1'b1, 4'd0);
    idleCheck("post-reset idle2", 1'b1, 4'd0);
    applyStimulus(1'b1, 8'h41, 2'd2, 1'b0, '0, 4'd0);
    checkOutput("post-reset alloc", 1'b0, 1'b1, 6'd0, 2'd2, 8'h41, 1'b0, '0, 4'd0);
    lockTail("post-reset", 4'd0);

    // Same-cycle update of row 0 must steer the class-0 lookup to row 1.
    applyStimulus(1'b1, 8'h42, 2'd0, 1'b1, 6'd0, 4'b0001);
    checkOutput("bypass", 1'b0, 1'b1, 6'd1, 2'd0, 8'h42, 1'b0, '0, 4'd0);
    lockTail("bypass", 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
